// File: rtl/clock_pkg.sv
// Shared clock-domain types and limits used by the time keeper, display and alarm blocks.
package clock_pkg;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned BCD_W    = 8;

  // Time of day as two-digit BCD fields, {tens, ones} per field.
  typedef struct packed {
    logic [BCD_W-1:0] hour;
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] sec;
  } bcd_time_t;

  // Converts a small binary value (0..99) to two-digit BCD.
  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD counter wrapping from MAX to 00; wrap flags the carry-out of an increment at MAX.
module bcd_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] val,
  output logic             wrap
);

  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX);

  logic             at_max;
  logic [BCD_W-1:0] val_nxt;

  assign at_max = (val == MAX_BCD);
  assign wrap   = inc && at_max;

  // Next value: clear wins, then BCD increment with digit carry and wrap at MAX.
  always_comb begin
    val_nxt = val;
    if (clr) begin
      val_nxt = '0;
    end else if (inc) begin
      if (at_max) begin
        val_nxt = '0;
      end else if (val[3:0] == 4'd9) begin
        val_nxt = {val[7:4] + 4'd1, 4'd0};
      end else begin
        val_nxt = {val[7:4], val[3:0] + 4'd1};
      end
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else begin
      val <= val_nxt;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler and adjust-mode field stepping.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adj_mode,
  input  logic             hour_en,
  input  logic             min_en,
  output logic [BCD_W-1:0] hour_bcd,
  output logic [BCD_W-1:0] min_bcd,
  output logic [BCD_W-1:0] sec_bcd,
  output logic             sec_tick,
  output logic             hour_chime
);

  localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             adj_q;
  logic             tick;
  logic             adj_entry;
  logic             sec_wrap;
  logic             min_wrap;
  logic             hour_wrap;
  logic             min_inc;
  logic             hour_inc;
  bcd_time_t        now;

  assign tick      = !adj_mode && (presc == CNT_LAST);
  assign adj_entry = adj_mode && !adj_q;

  // In adjust mode the fields step only from the pulses, so an adjusted
  // minute wrap never reaches the hour counter or the chime.
  assign min_inc  = adj_mode ? min_en  : sec_wrap;
  assign hour_inc = adj_mode ? hour_en : min_wrap;

  // Prescaler: free-running in normal mode, held at 0 while adjusting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (adj_mode || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Mode history and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_q      <= 1'b0;
      sec_tick   <= 1'b0;
      hour_chime <= 1'b0;
    end else begin
      adj_q      <= adj_mode;
      sec_tick   <= tick;
      hour_chime <= !adj_mode && min_wrap;
    end
  end

  bcd_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick),
    .clr   (adj_entry),
    .val   (now.sec),
    .wrap  (sec_wrap)
  );

  bcd_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .val   (now.min),
    .wrap  (min_wrap)
  );

  bcd_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .clr   (1'b0),
    .val   (now.hour),
    .wrap  (hour_wrap)
  );

  // A day rollover only comes from a minute carry or an explicit hour step.
  a_day_wrap_src: assert property (@(posedge clk) disable iff (!rst_n)
    hour_wrap |-> (min_wrap || hour_en));

  assign hour_bcd = now.hour;
  assign min_bcd  = now.min;
  assign sec_bcd  = now.sec;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper with a 4-cycle second.
module tb_time_keeper;

  logic       clk;
  logic       rst_n;
  logic       adj_mode;
  logic       hour_en;
  logic       min_en;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       sec_tick;
  logic       hour_chime;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_ticks;
  int unsigned n_chimes;
  logic [7:0]  sec_seen;

  time_keeper #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adj_mode   (adj_mode),
    .hour_en    (hour_en),
    .min_en     (min_en),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .sec_tick   (sec_tick),
    .hour_chime (hour_chime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_count(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step(1);
      if (sec_tick)   n_ticks++;
      if (hour_chime) n_chimes++;
    end
  endtask

  task automatic pulse(input logic h, input logic m, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hour_en = h;
      min_en  = m;
      step(1);
      if (hour_chime) n_chimes++;
      hour_en = 1'b0;
      min_en  = 1'b0;
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    check({tag, ".time"}, {8'h00, hour_bcd, min_bcd, sec_bcd}, {8'h00, h, m, s});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    adj_mode = 1'b0;
    hour_en  = 1'b0;
    min_en   = 1'b0;

    // Reset state
    #12;
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset.tick", sec_tick, 0);
    check("reset.chime", hour_chime, 0);

    // First tick exactly TICK_DIV edges after release, period 4
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    check_time("pre_tick1", 8'h00, 8'h00, 8'h00);
    check("pre_tick1.tick", sec_tick, 0);
    step(1);
    check_time("tick1", 8'h00, 8'h00, 8'h01);
    check("tick1.tick", sec_tick, 1);
    step(1);
    check("tick1.tick_off", sec_tick, 0);
    step(3);
    check("tick2.tick", sec_tick, 1);
    check_time("tick2", 8'h00, 8'h00, 8'h02);

    // Preload 23:59 via adjust, then run into midnight
    adj_mode = 1'b1;
    step(1);
    check_time("adj_entry", 8'h00, 8'h00, 8'h00);
    n_chimes = 0;
    pulse(1'b1, 1'b0, 23);
    pulse(1'b0, 1'b1, 59);
    check_time("preload_2359", 8'h23, 8'h59, 8'h00);
    adj_mode = 1'b0;
    step_count(236);
    check_time("run_235959", 8'h23, 8'h59, 8'h59);
    step(3);
    check("pre_midnight.chime", hour_chime, 0);
    check_time("pre_midnight", 8'h23, 8'h59, 8'h59);
    step(1);
    check_time("midnight", 8'h00, 8'h00, 8'h00);
    check("midnight.chime", hour_chime, 1);
    check("midnight.tick", sec_tick, 1);
    step(1);
    check("midnight.chime_off", hour_chime, 0);

    // Adjust wraparound: 25 hour steps, 61 minute steps
    adj_mode = 1'b1;
    step(1);
    pulse(1'b1, 1'b0, 25);
    check_time("hour25", 8'h01, 8'h00, 8'h00);
    pulse(1'b0, 1'b1, 61);
    check_time("min61", 8'h01, 8'h01, 8'h00);
    check("adj.no_chime", n_chimes, 0);

    // Enter adjust at 12:34:27 mid-prescale
    pulse(1'b1, 1'b0, 11);
    pulse(1'b0, 1'b1, 33);
    adj_mode = 1'b0;
    step(108);
    check_time("run_123427", 8'h12, 8'h34, 8'h27);
    step(2);
    adj_mode = 1'b1;
    step(1);
    check_time("adj_mid", 8'h12, 8'h34, 8'h00);
    n_ticks  = 0;
    sec_seen = 8'h00;
    for (int unsigned i = 0; i < 100; i++) begin
      step(1);
      if (sec_tick) n_ticks++;
      sec_seen = sec_seen | sec_bcd;
    end
    check("adj_hold.ticks", n_ticks, 0);
    check("adj_hold.sec", sec_seen, 8'h00);
    adj_mode = 1'b0;
    step(3);
    check("exit.pre_tick", sec_tick, 0);
    check_time("exit.pre", 8'h12, 8'h34, 8'h00);
    step(1);
    check("exit.tick", sec_tick, 1);
    check_time("exit.tick", 8'h12, 8'h34, 8'h01);

    // Simultaneous pulses at 23:59 in adjust
    adj_mode = 1'b1;
    step(1);
    n_chimes = 0;
    pulse(1'b1, 1'b0, 11);
    pulse(1'b0, 1'b1, 25);
    check_time("both_pre", 8'h23, 8'h59, 8'h00);
    pulse(1'b1, 1'b1, 1);
    check_time("both", 8'h00, 8'h00, 8'h00);
    step(1);
    check("both.no_chime", n_chimes + hour_chime, 0);

    // Pulses ignored outside adjust mode
    adj_mode = 1'b0;
    pulse(1'b1, 1'b1, 1);
    check_time("normal_pulses", 8'h00, 8'h00, 8'h00);

    // Asynchronous reset mid-count at 05:06:07
    adj_mode = 1'b1;
    step(1);
    pulse(1'b1, 1'b0, 5);
    pulse(1'b0, 1'b1, 6);
    adj_mode = 1'b0;
    step(28);
    step(2);
    check_time("run_050607", 8'h05, 8'h06, 8'h07);
    rst_n = 1'b0;
    #2;
    check_time("async_reset", 8'h00, 8'h00, 8'h00);
    check("async_reset.tick", sec_tick, 0);
    #2;
    rst_n = 1'b1;
    step(3);
    check_time("rst_pre_tick", 8'h00, 8'h00, 8'h00);
    step(1);
    check_time("rst_tick", 8'h00, 8'h00, 8'h01);
    check("rst_tick.tick", sec_tick, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
